// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one CORDIC pipeline between NREQ angle requesters.
// A {valid, id} tag rides alongside the pipeline so each result is returned labelled with its requester.
module cordic_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          LATENCY = 16,
  parameter logic [15:0] INIT_X  = 16'd19895,
  localparam int         IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [16*NREQ-1:0]      req_angle_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    cordic_en_o,
  output logic [15:0]             cordic_angle_o,
  output logic [15:0]             cordic_x0_o,
  output logic [15:0]             cordic_y0_o,
  input  logic signed [15:0]      cordic_x_i,
  input  logic signed [15:0]      cordic_y_i,
  input  logic                    cordic_done_i,
  output logic                    rsp_valid_o,
  output logic [IDW-1:0]          rsp_id_o,
  output logic signed [15:0]      rsp_cos_o,
  output logic signed [15:0]      rsp_sin_o,
  output logic                    busy_o,
  output logic                    err_o
);

  logic [IDW-1:0] last_q, last_d;
  logic           issue_v_q, issue_v_d;
  logic [IDW-1:0] issue_id_q, issue_id_d;
  logic [15:0]    angle_q, angle_d;

  logic [15:0]    angle_arr [NREQ];
  logic [IDW:0]   cand_sum  [NREQ];
  logic [IDW:0]   cand_wrap [NREQ];
  logic [IDW-1:0] cand_id   [NREQ];
  logic [NREQ-1:0] cand_hit;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [15:0]    grant_angle;

  // Candidate k is requester (last+1+k) mod NREQ; one conditional subtract is enough.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign angle_arr[gi] = req_angle_i[16*gi +: 16];
    assign cand_sum[gi]  = {1'b0, last_q} + (IDW+1)'(gi + 1);
    assign cand_wrap[gi] = cand_sum[gi] - (IDW+1)'(NREQ);
    assign cand_id[gi]   = (cand_sum[gi] >= (IDW+1)'(NREQ)) ? cand_wrap[gi][IDW-1:0]
                                                           : cand_sum[gi][IDW-1:0];
    assign cand_hit[gi]  = req_valid_i[cand_id[gi]];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_found = 1'b1;
        grant_id    = cand_id[k];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready_o[gi] = grant_found && (grant_id == IDW'(gi));
  end

  assign grant_angle = angle_arr[grant_id];

  // A grant is only ever given to a valid requester, so a grant is a completed handshake.
  always_comb begin
    last_d     = last_q;
    issue_v_d  = grant_found;
    issue_id_d = issue_id_q;
    angle_d    = angle_q;
    if (grant_found) begin
      last_d     = grant_id;
      issue_id_d = grant_id;
      angle_d    = grant_angle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= IDW'(NREQ - 1);
      issue_v_q  <= 1'b0;
      issue_id_q <= '0;
      angle_q    <= '0;
    end else begin
      last_q     <= last_d;
      issue_v_q  <= issue_v_d;
      issue_id_q <= issue_id_d;
      angle_q    <= angle_d;
    end
  end

  assign cordic_en_o    = issue_v_q;
  assign cordic_angle_o = angle_q;
  assign cordic_x0_o    = INIT_X;
  assign cordic_y0_o    = 16'd0;

  logic [LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
    logic           v_d;
    logic [IDW-1:0] id_d;
    if (gi == 0) begin : g_head
      assign v_d  = issue_v_q;
      assign id_d = issue_id_q;
    end else begin : g_body
      assign v_d  = tag_v_q[gi-1];
      assign id_d = tag_id_q[gi-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_v_q[gi]  <= 1'b0;
        tag_id_q[gi] <= '0;
      end else begin
        tag_v_q[gi]  <= v_d;
        tag_id_q[gi] <= id_d;
      end
    end
  end

  logic                tail_v;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic signed [15:0]  rsp_cos_q, rsp_cos_d;
  logic signed [15:0]  rsp_sin_q, rsp_sin_d;
  logic                err_q, err_d;

  assign tail_v = tag_v_q[LATENCY-1];

  always_comb begin
    rsp_valid_d = tail_v;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    if (tail_v) begin
      rsp_id_d  = tag_id_q[LATENCY-1];
      rsp_cos_d = cordic_x_i;
      rsp_sin_d = cordic_y_i;
    end
    err_d = err_q | (tail_v != cordic_done_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_cos_o   = rsp_cos_q;
  assign rsp_sin_o   = rsp_sin_q;
  assign err_o       = err_q;
  assign busy_o      = issue_v_q | (|tag_v_q);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a stand-in CORDIC pipeline plus a round-robin/scoreboard reference model.
module tb_cordic_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_angle;
  logic [NREQ-1:0]    req_ready;
  logic cordic_en, cordic_done, rsp_valid, busy, err;
  logic [15:0] cordic_angle, cordic_x0, cordic_y0;
  logic signed [15:0] cordic_x, cordic_y, rsp_cos, rsp_sin;
  logic [1:0] rsp_id;
  logic force_done;

  always #5 clk = ~clk;

  cordic_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .INIT_X(16'd19895)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_angle_i(req_angle), .req_ready_o(req_ready),
    .cordic_en_o(cordic_en), .cordic_angle_o(cordic_angle),
    .cordic_x0_o(cordic_x0), .cordic_y0_o(cordic_y0),
    .cordic_x_i(cordic_x), .cordic_y_i(cordic_y), .cordic_done_i(cordic_done),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_cos_o(rsp_cos), .rsp_sin_o(rsp_sin),
    .busy_o(busy), .err_o(err)
  );

  // Stand-in pipeline: fixed latency, distinctive bit patterns so pass-through is checked bit-exact.
  function automatic logic [15:0] stub_x(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction
  function automatic logic [15:0] stub_y(input logic [15:0] a);
    return {a[7:0], a[15:8]} + 16'd1;
  endfunction

  logic        p_v [LAT];
  logic [15:0] p_a [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin p_v[k] <= 1'b0; p_a[k] <= '0; end
    end else begin
      p_v[0] <= cordic_en;
      p_a[0] <= cordic_angle;
      for (int k = 1; k < LAT; k++) begin p_v[k] <= p_v[k-1]; p_a[k] <= p_a[k-1]; end
    end
  end
  assign cordic_done = p_v[LAT-1] | force_done;
  assign cordic_x    = stub_x(p_a[LAT-1]);
  assign cordic_y    = stub_y(p_a[LAT-1]);

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [15:0] ang; int due; } pend_t;
  pend_t q[$];
  int    m_last;
  logic  m_en;

  typedef struct {
    logic [NREQ-1:0] rdy, rdy_x;
    logic en, en_x, rv, rv_x, busy, busy_x, err;
    logic [1:0] id, id_x;
    logic [15:0] c, c_x, s, s_x;
  } obs_t;

  task automatic model_reset();
    q.delete();
    m_last = NREQ - 1;
    m_en   = 1'b0;
  endtask

  // Drives one cycle (called just after a falling edge), samples the DUT, advances the reference model.
  task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] a, output obs_t o);
    pend_t p;
    int base, i;
    req_valid = v;
    req_angle = a;
    #1;
    o.rdy = req_ready; o.en = cordic_en; o.rv = rsp_valid; o.id = rsp_id;
    o.c = rsp_cos; o.s = rsp_sin; o.busy = busy; o.err = err;
    o.en_x = m_en;
    o.rv_x = 1'b0; o.id_x = '0; o.c_x = '0; o.s_x = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      p = q.pop_front();
      o.rv_x = 1'b1; o.id_x = 2'(p.id); o.c_x = stub_x(p.ang); o.s_x = stub_y(p.ang);
    end
    o.busy_x = (q.size() > 0) || m_en;
    o.rdy_x = '0;
    m_en = 1'b0;
    base = m_last;
    for (int k = 1; k <= NREQ; k++) begin
      i = (base + k) % NREQ;
      if (!m_en && v[i]) begin
        o.rdy_x[i] = 1'b1;
        m_en = 1'b1;
        m_last = i;
        q.push_back('{i, a[16*i +: 16], cyc + LAT + 2});
      end
    end
    if (o.rv) $display("rsp cyc=%0d id=%0d cos=%h sin=%h", cyc, o.id, o.c, o.s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; force_done = 1'b0; req_valid = '0; req_angle = '0;
    #2;
    checks++;
    if ({cordic_en, rsp_valid, busy, err, cordic_angle, rsp_id, rsp_cos, rsp_sin, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b rv=%b busy=%b err=%b ang=%h id=%0d cos=%h sin=%h rdy=%b required all zero",
               cordic_en, rsp_valid, busy, err, cordic_angle, rsp_id, rsp_cos, rsp_sin, req_ready);
    end
    checks++;
    if (cordic_x0 !== 16'd19895 || cordic_y0 !== 16'd0) begin
      errors++;
      $display("FAIL start_vector got x0=%0d y0=%0d required 19895 0", cordic_x0, cordic_y0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    obs_t o;
    int nrsp = 0;
    logic [16*NREQ-1:0] a = '0;
    a[32 +: 16] = 16'd8000;
    drive_cycle(4'b0100, a, o);
    checks++;
    if (o.rdy !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b required=0100", o.rdy); end
    for (int t = 0; t < LAT + 4; t++) begin
      drive_cycle('0, a, o);
      checks++;
      if (o.rv !== o.rv_x || (o.rv_x && (o.id !== o.id_x || o.c !== o.c_x || o.s !== o.s_x))) begin
        errors++;
        $display("FAIL single_rsp cyc=%0d got v=%b id=%0d cos=%h sin=%h required v=%b id=%0d cos=%h sin=%h",
                 cyc, o.rv, o.id, o.c, o.s, o.rv_x, o.id_x, o.c_x, o.s_x);
      end
      if (o.rv) nrsp++;
    end
    checks++;
    if (nrsp != 1 || err !== 1'b0) begin errors++; $display("FAIL single_count got rsp=%0d err=%b required 1 0", nrsp, err); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    int gcnt [NREQ];
    logic [16*NREQ-1:0] a;
    for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
    for (int t = 0; t < 40 + LAT + 3; t++) begin
      a = {$urandom, $urandom};
      drive_cycle((t < 40) ? 4'b1111 : 4'b0000, a, o);
      checks++;
      if (o.rdy !== o.rdy_x || o.en !== o.en_x) begin
        errors++;
        $display("FAIL rr_grant cyc=%0d got rdy=%b en=%b required rdy=%b en=%b", cyc, o.rdy, o.en, o.rdy_x, o.en_x);
      end
      checks++;
      if (o.rv !== o.rv_x || (o.rv_x && (o.id !== o.id_x || o.c !== o.c_x || o.s !== o.s_x))) begin
        errors++;
        $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d required v=%b id=%0d", cyc, o.rv, o.id, o.rv_x, o.id_x);
      end
      for (int k = 0; k < NREQ; k++) if (o.rdy[k]) gcnt[k]++;
    end
    for (int k = 0; k < NREQ; k++) begin
      checks++;
      if (gcnt[k] != 10) begin errors++; $display("FAIL rr_count req=%0d got=%0d required=10", k, gcnt[k]); end
    end
  endtask

  task automatic test_drop();
    obs_t o;
    logic v3 = 1'b1;
    int g3 = 0;
    logic [NREQ-1:0] v;
    for (int t = 0; t < 12 + LAT + 3; t++) begin
      v = (t < 12) ? {v3, 1'b0, 1'b1, 1'b0} : 4'b0000;
      drive_cycle(v, {$urandom, $urandom}, o);
      checks++;
      if (o.rdy !== o.rdy_x || (o.rdy & ~v) !== '0) begin
        errors++;
        $display("FAIL drop_grant cyc=%0d got rdy=%b required rdy=%b valid=%b", cyc, o.rdy, o.rdy_x, v);
      end
      checks++;
      if (o.rv !== o.rv_x || (o.rv_x && (o.id !== o.id_x || o.c !== o.c_x || o.s !== o.s_x))) begin
        errors++;
        $display("FAIL drop_rsp cyc=%0d got v=%b id=%0d required v=%b id=%0d", cyc, o.rv, o.id, o.rv_x, o.id_x);
      end
      if (o.rdy[3]) g3++;
      if (g3 == 2) v3 = 1'b0;
    end
    checks++;
    if (g3 != 2) begin errors++; $display("FAIL drop_count got=%0d required=2", g3); end
  endtask

  task automatic test_sweep();
    obs_t o;
    int nhs = 0, nrsp = 0, ang = 0, idle = 0;
    logic [16*NREQ-1:0] a;
    while (idle < LAT + 4) begin
      a = {$urandom, $urandom};
      if (ang <= 32767) a[15:0] = 16'(ang);
      drive_cycle((ang <= 32767) ? 4'b0001 : 4'b0000, a, o);
      if (ang <= 32767) ang += 5; else idle++;
      if (o.rdy[0]) nhs++;
      if (o.rv) nrsp++;
      checks++;
      if (o.rv !== o.rv_x || (o.rv_x && (o.id !== 2'd0 || o.c !== o.c_x || o.s !== o.s_x))) begin
        errors++;
        $display("FAIL sweep_rsp cyc=%0d got v=%b id=%0d cos=%h sin=%h required v=%b id=0 cos=%h sin=%h",
                 cyc, o.rv, o.id, o.c, o.s, o.rv_x, o.c_x, o.s_x);
      end
      checks++;
      if (o.busy !== o.busy_x) begin
        errors++;
        $display("FAIL sweep_busy cyc=%0d got=%b required=%b", cyc, o.busy, o.busy_x);
      end
    end
    checks++;
    if (nhs != 6554 || nrsp != nhs) begin
      errors++;
      $display("FAIL sweep_count got hs=%0d rsp=%0d required 6554 6554", nhs, nrsp);
    end
  endtask

  task automatic test_mid_reset();
    obs_t o;
    for (int t = 0; t < 10; t++) drive_cycle(4'b0001, {$urandom, $urandom}, o);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cordic_en, rsp_valid, busy, err, cordic_angle, rsp_id, rsp_cos, rsp_sin} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got en=%b rv=%b busy=%b ang=%h required all zero", cordic_en, rsp_valid, busy, cordic_angle);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < LAT + 4; t++) begin
      drive_cycle('0, '0, o);
      checks++;
      if (o.rv !== 1'b0 || o.busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cyc=%0d got rv=%b busy=%b required 0 0", cyc, o.rv, o.busy);
      end
    end
    drive_cycle(4'b1111, {$urandom, $urandom}, o);
    checks++;
    if (o.rdy !== 4'b0001) begin errors++; $display("FAIL midreset_first got=%b required=0001", o.rdy); end
    for (int t = 0; t < LAT + 3; t++) drive_cycle('0, '0, o);
  endtask

  task automatic test_err();
    obs_t o;
    force_done = 1'b1;
    drive_cycle('0, '0, o);
    force_done = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_cycle('0, '0, o);
      checks++;
      if (o.err !== 1'b1 || o.rv !== 1'b0) begin
        errors++;
        $display("FAIL err_sticky cyc=%0d got err=%b rv=%b required 1 0", cyc, o.err, o.rv);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b required=0", err); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_sweep();
    test_mid_reset();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
